// File: rtl/spi_if.sv
// ---------------------------------------------------------------------------
// spi_if -- bundle of the request, serial and status signals of spi_master.
//
// Signals:
//   start    : request a frame (sampled by the master only while idle)
//   cmd[1:0] : frame command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data)
//   din[7:0] : frame payload (address or data)
//   MISO     : serial data from slave
//   SS_n     : active-low slave select
//   MOSI     : serial data to slave
//   busy     : high while a frame is in progress
//   done     : one-cycle pulse at frame end
//   rd_data  : byte received on the last read-data frame
//   rd_valid : one-cycle pulse, rd_data updated
//   err      : one-cycle pulse, request rejected
//
// Modports: master (the SPI master block), slave (the requester / bench side).
// ---------------------------------------------------------------------------
interface spi_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       MISO;
    logic       SS_n;
    logic       MOSI;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       err;

    modport master (
        input  start, cmd, din, MISO,
        output SS_n, MOSI, busy, done, rd_data, rd_valid, err
    );

    modport slave (
        output start, cmd, din, MISO,
        input  SS_n, MOSI, busy, done, rd_data, rd_valid, err
    );
endinterface

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master -- frame-level SPI master.
//
// A frame is: select, one path-select bit (cmd[1]), the 10-bit word
// {cmd,din} MSB first, then either end of frame or, for read-data frames,
// MISO_DLY idle cycles followed by 8 MISO samples (MSB first).
//
// Parameters:
//   MISO_DLY : idle cycles between last MOSI bit and first MISO sample (1..7)
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : spi_if.master (start/cmd/din/MISO in; SS_n/MOSI/busy/done/
//         rd_data/rd_valid/err out). All outputs are registered.
//
// Optional feature (macro SPI_MASTER_RDADDR_CHECK_EN):
//   When defined, a read-data request (cmd 11) is rejected with an err pulse
//   unless a read-address frame (cmd 10) has completed since the last reset
//   or the last completed read-data frame. When undefined, err is always 0.
// ---------------------------------------------------------------------------
module spi_master #(
    parameter int MISO_DLY = 2
) (
    input  logic  clk,
    input  logic  rst,
    spi_if.master bus
);

    typedef enum logic [2:0] {IDLE, SEL, CMD, SHIFT, WAIT, RECV, END} state_t;

    state_t     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] din_q, din_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] shift_q, shift_d;

    // Output registers; their _d values describe the cycle after the edge.
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       err_q, err_d;

    logic [9:0] word;
    logic       reject;

    assign word = {cmd_q, din_q};

`ifdef SPI_MASTER_RDADDR_CHECK_EN
    logic rd_addr_sent_q;

    // Set by a completed read-address frame, consumed by a completed
    // read-data frame; both events are seen in the END cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_sent_q <= 1'b0;
        end else if (state_q == END && cmd_q == 2'b10) begin
            rd_addr_sent_q <= 1'b1;
        end else if (state_q == END && cmd_q == 2'b11) begin
            rd_addr_sent_q <= 1'b0;
        end
    end

    assign reject = (bus.cmd == 2'b11) && !rd_addr_sent_q;
`else
    assign reject = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        din_d      = din_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        ss_n_d     = 1'b1;
        mosi_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_d   = bus.cmd;
                        din_d   = bus.din;
                        state_d = SEL;
                        ss_n_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            SEL: begin
                state_d = CMD;
                ss_n_d  = 1'b0;
                busy_d  = 1'b1;
                mosi_d  = cmd_q[1];
            end
            CMD: begin
                state_d   = SHIFT;
                ss_n_d    = 1'b0;
                busy_d    = 1'b1;
                bit_cnt_d = 4'd9;
                mosi_d    = word[9];
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (bit_cnt_q == 4'd0) begin
                    if (cmd_q == 2'b11) begin
                        state_d    = WAIT;
                        ss_n_d     = 1'b0;
                        wait_cnt_d = 3'(MISO_DLY - 1);
                    end else begin
                        state_d = END;
                        done_d  = 1'b1;
                    end
                end else begin
                    ss_n_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    mosi_d    = word[bit_cnt_q - 4'd1];
                end
            end
            WAIT: begin
                ss_n_d = 1'b0;
                busy_d = 1'b1;
                if (wait_cnt_q == 3'd0) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd7;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            RECV: begin
                busy_d  = 1'b1;
                shift_d = {shift_q[6:0], bus.MISO};
                if (bit_cnt_q == 4'd0) begin
                    // Last sample goes straight into rd_data so it is valid
                    // in the END cycle together with done/rd_valid.
                    state_d    = END;
                    done_d     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = {shift_q[6:0], bus.MISO};
                end else begin
                    ss_n_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= 2'b00;
            din_q      <= 8'h00;
            bit_cnt_q  <= 4'd0;
            wait_cnt_q <= 3'd0;
            shift_q    <= 8'h00;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            din_q      <= din_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            shift_q    <= shift_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master -- self-checking bench for spi_master.
//
// Cycle k of a frame is the k-th clock period after the edge that samples
// start; outputs are sampled on the falling edge. The reference model
// derives the expected per-cycle waveform directly from the frame rules
// (frame lengths, bit positions, read-data byte) and tracks rd_data and the
// read-address flag across frames.
// ---------------------------------------------------------------------------
module tb_spi_master;

    localparam int MISO_DLY = 2;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Model state carried between frames.
    logic [7:0] exp_rd_data;
    bit         rd_addr_sent;

    spi_if bus ();

    spi_master #(.MISO_DLY(MISO_DLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one frame from cycle 0 (start driven now, sampled at next edge)
    // through the cycle after END, comparing every output every cycle.
    // With hold=1 start is left high throughout and on return.
    task automatic run_frame(input string tag, input logic [1:0] c,
                             input logic [7:0] d, input logic [7:0] mb,
                             input bit hold);
        int         e_end;
        int         n;
        bit         rej;
        logic [9:0] w;
        logic       e_ss, e_busy, e_mosi, e_done, e_rv, e_err;
        logic [7:0] e_rd;

        rej = 1'b0;
`ifdef SPI_MASTER_RDADDR_CHECK_EN
        rej = (c == 2'b11) && !rd_addr_sent;
`endif
        w     = {c, d};
        e_end = (c == 2'b11) ? 21 + MISO_DLY : 13;
        n     = rej ? 2 : e_end + 1;

        bus.start = 1'b1;
        bus.cmd   = c;
        bus.din   = d;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) bus.start = 1'b0;

            e_ss   = (!rej && k < e_end) ? 1'b0 : 1'b1;
            e_busy = !rej && k <= e_end;
            e_mosi = 1'b0;
            if (!rej && k == 2) e_mosi = c[1];
            if (!rej && k >= 3 && k <= 12) e_mosi = w[12 - k];
            e_done = !rej && k == e_end;
            e_rv   = e_done && c == 2'b11;
            e_rd   = (!rej && c == 2'b11 && k >= e_end) ? mb : exp_rd_data;
            e_err  = rej && k == 1;

            tests++;
            if (bus.SS_n !== e_ss) begin
                fails++;
                $display("FAIL %s c%0d SS_n got %b exp %b", tag, k, bus.SS_n, e_ss);
            end
            tests++;
            if (bus.MOSI !== e_mosi) begin
                fails++;
                $display("FAIL %s c%0d MOSI got %b exp %b", tag, k, bus.MOSI, e_mosi);
            end
            tests++;
            if (bus.busy !== e_busy) begin
                fails++;
                $display("FAIL %s c%0d busy got %b exp %b", tag, k, bus.busy, e_busy);
            end
            tests++;
            if (bus.done !== e_done) begin
                fails++;
                $display("FAIL %s c%0d done got %b exp %b", tag, k, bus.done, e_done);
            end
            tests++;
            if (bus.rd_valid !== e_rv) begin
                fails++;
                $display("FAIL %s c%0d rd_valid got %b exp %b", tag, k, bus.rd_valid, e_rv);
            end
            tests++;
            if (bus.rd_data !== e_rd) begin
                fails++;
                $display("FAIL %s c%0d rd_data got %h exp %h", tag, k, bus.rd_data, e_rd);
            end
            tests++;
            if (bus.err !== e_err) begin
                fails++;
                $display("FAIL %s c%0d err got %b exp %b", tag, k, bus.err, e_err);
            end

            // Slave model: the byte occupies the 8 cycles after the wait
            // window; any other cycle carries noise.
            if (c == 2'b11 && k >= 13 + MISO_DLY && k <= 20 + MISO_DLY)
                bus.MISO = mb[7 - (k - 13 - MISO_DLY)];
            else
                bus.MISO = 1'($urandom);
        end

        if (!rej && c == 2'b11) begin
            exp_rd_data  = mb;
            rd_addr_sent = 1'b0;
        end
        if (!rej && c == 2'b10) rd_addr_sent = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.cmd   = 2'b00;
        bus.din   = 8'h00;
        bus.MISO  = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.SS_n, bus.MOSI, bus.busy, bus.done, bus.rd_valid, bus.err} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags got %b exp 100000",
                     {bus.SS_n, bus.MOSI, bus.busy, bus.done, bus.rd_valid, bus.err});
        end
        tests++;
        if (bus.rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_rd_data got %h exp 00", bus.rd_data);
        end
        rst          = 1'b0;
        exp_rd_data  = 8'h00;
        rd_addr_sent = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.SS_n, bus.busy} !== 2'b10) begin
            fails++;
            $display("FAIL idle_after_reset got %b exp 10", {bus.SS_n, bus.busy});
        end
    endtask

    // Directly after reset no read address has been sent: the check build
    // rejects cmd 11, the default build accepts it. Then addr + data.
    task automatic test_rdaddr_check();
        run_frame("rdaddr_first", 2'b11, 8'($urandom), 8'($urandom), 1'b0);
        run_frame("rdaddr_addr", 2'b10, 8'($urandom), 8'($urandom), 1'b0);
        run_frame("rdaddr_data", 2'b11, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic test_write_addr();
        run_frame("wr_addr_a5", 2'b00, 8'hA5, 8'($urandom), 1'b0);
    endtask

    task automatic test_read_seq();
        run_frame("rd_addr_3c", 2'b10, 8'h3C, 8'($urandom), 1'b0);
        run_frame("rd_data_96", 2'b11, 8'($urandom), 8'h96, 1'b0);
        tests++;
        if (bus.rd_data !== 8'h96) begin
            fails++;
            $display("FAIL rd_seq_hold got %h exp 96", bus.rd_data);
        end
    endtask

    // start stays high across a whole frame: only one frame may go out,
    // and the next one must start exactly at cycle 14.
    task automatic test_busy_collision();
        run_frame("collide_1", 2'b01, 8'hFF, 8'($urandom), 1'b1);
        run_frame("collide_2", 2'b01, 8'hFF, 8'($urandom), 1'b0);
    endtask

    task automatic test_reset_mid_recv();
        run_frame("abort_addr", 2'b10, 8'($urandom), 8'($urandom), 1'b0);
        bus.start = 1'b1;
        bus.cmd   = 2'b11;
        bus.din   = 8'($urandom);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            bus.MISO  = 1'b1;
        end
        tests++;
        if (bus.SS_n !== 1'b0) begin
            fails++;
            $display("FAIL abort_pre_ss got %b exp 0", bus.SS_n);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.SS_n, bus.busy, bus.rd_data} !== {2'b10, 8'h00}) begin
            fails++;
            $display("FAIL abort_async got %b_%b_%h exp 1_0_00",
                     bus.SS_n, bus.busy, bus.rd_data);
        end
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({bus.done, bus.rd_valid} !== 2'b00) begin
                fails++;
                $display("FAIL abort_no_pulse got %b exp 00", {bus.done, bus.rd_valid});
            end
        end
        rst          = 1'b0;
        exp_rd_data  = 8'h00;
        rd_addr_sent = 1'b0;
        @(negedge clk);
        run_frame("abort_fresh", 2'b00, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_frame($sformatf("rand%0d", i), 2'($urandom_range(0, 3)),
                      8'($urandom), 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        exp_rd_data  = 8'h00;
        rd_addr_sent = 1'b0;
        test_reset();
        test_rdaddr_check();
        test_write_addr();
        test_read_seq();
        test_busy_collision();
        test_reset_mid_recv();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter MISO_DLY, default 2: idle cycles between the last MOSI frame bit and the first MISO sample on read-data frames (legal 1..7).
REQ-002 SHALL provide port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL provide port start  input  1  request a frame; sampled only in IDLE.
REQ-005 SHALL provide port cmd  input  2  frame command: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-006 SHALL provide port din  input  8  frame payload (address or data).
REQ-007 SHALL provide port MISO  input  1  serial data from slave.
REQ-008 SHALL provide port SS_n  output  1  active-low slave select.
REQ-009 SHALL provide port MOSI  output  1  serial data to slave.
REQ-010 SHALL provide port busy  output  1  high while a frame is in progress.
REQ-011 SHALL provide port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL provide port rd_data  output  8  byte received on a read-data frame.
REQ-013 SHALL provide port rd_valid  output  1  one-cycle pulse, rd_data updated.
REQ-014 SHALL provide port err  output  1  one-cycle pulse, request rejected (see Configuration).

Function
REQ-015 SHALL implement states IDLE, SEL, CMD, SHIFT, WAIT, RECV, END; all outputs registered.
REQ-016 SHALL, in IDLE with start=1 (cycle 0), latch cmd/din into internal registers and go to SEL; start while not in IDLE SHALL be ignored.
REQ-017 SHALL, in SEL (cycle 1), drive SS_n=0, MOSI=0, busy=1.
REQ-018 SHALL, in CMD (cycle 2), drive MOSI=latched cmd[1] (slave path-select bit).
REQ-019 SHALL, in SHIFT (cycles 3..12), drive the 10-bit word {cmd,din} MSB first, one bit per cycle, using a 4-bit bit counter.
REQ-020 SHALL, after SHIFT, go to END for cmd 00/01/10, and to WAIT for cmd 11.
REQ-021 SHALL hold SS_n=0, MOSI=0 in WAIT for exactly MISO_DLY cycles, then enter RECV.
REQ-022 SHALL, in RECV, sample MISO on 8 consecutive edges, MSB first, into a shift register, SS_n held 0.
REQ-023 SHALL, in END, drive SS_n=1, MOSI=0, pulse done=1; for cmd 11 also load rd_data and pulse rd_valid in the same cycle.
REQ-024 SHALL return from END to IDLE with busy=0 the next cycle; SS_n therefore stays high at least 2 cycles between frames.
REQ-025 Latency: write/read-address frame done at cycle 13; read-data frame done at cycle 21+MISO_DLY.
REQ-026 SHALL hold rd_data between read-data frames; non-read frames SHALL NOT alter it.
REQ-027 SHALL keep done, rd_valid, err low in all cycles not stated above.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_data=0x00, rd_valid=0, err=0, counters and latches 0.
REQ-029 SHALL abort a frame on reset mid-operation: SS_n deasserts asynchronously, no done/rd_valid emitted, first start after release begins a fresh frame.

Configuration
REQ-030 Macro SPI_MASTER_RDADDR_CHECK_EN SHALL, when defined, track a "read address sent" flag (set on completed cmd 10, cleared on completed cmd 11 or reset); start with cmd 11 while flag clear SHALL pulse err for one cycle, stay in IDLE, leave SS_n=1.
REQ-031 Without SPI_MASTER_RDADDR_CHECK_EN, cmd 11 SHALL always be accepted and err SHALL be tied 0.

Verification
REQ-032 Write address: start, cmd=00, din=0xA5 -> SS_n low cycles 1..12, MOSI cycle 2=0, cycles 3..12 = 0,0,1,0,1,0,0,1,0,1; done at cycle 13.
REQ-033 Read sequence: cmd=10 din=0x3C, then cmd=11, slave model returns 0x96 after MISO_DLY=2 -> rd_data=0x96, rd_valid and done at cycle 23 of second frame.
REQ-034 Busy collision: start held high throughout a write-data frame (cmd=01, din=0xFF) -> exactly one frame sent, next accepted in cycle 14 earliest.
REQ-035 Reset mid-RECV: assert rst at cycle 17 of read-data frame -> SS_n=1 immediately, no rd_valid, rd_data=0x00.
REQ-036 With SPI_MASTER_RDADDR_CHECK_EN: cmd=11 after reset -> err pulse, SS_n stays 1; repeated after cmd 10 -> accepted, err=0.
